pipe_hazard_ctrl: RTL and testbench
===================================

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL have parameter NSTAGE, default 5, meaning pipeline depth; legal range 5..8. Stage 0 is IF, 1 is ID, 2 is EX, 3 is MEM, NSTAGE-1 is WB.
REQ-002 SHALL have parameter AW, default 5, meaning register-address width.
REQ-003 SHALL derive SW = clog2(NSTAGE), the forward-select width.
REQ-004 clk_i  in  1  single clock; all state updates on its rising edge.
REQ-005 reset_i  in  1  synchronous, active-low reset.
REQ-006 id_valid_i  in  1  ID holds a real instruction.
REQ-007 id_rs1_i, id_rs2_i  in  AW each  ID source registers.
REQ-008 id_use_rs1_i, id_use_rs2_i  in  1 each  source is actually read.
REQ-009 id_rd_i  in  AW  ID destination register.
REQ-010 id_reg_write_i  in  1  ID instruction writes rd.
REQ-011 id_mem_read_i  in  1  ID instruction is a load.
REQ-012 ex_redirect_i  in  1  EX resolved a taken branch or jump; ignored unless valid_o[2].
REQ-013 stall_o  out  1  hold PC and the IF/ID register.
REQ-014 flush_o  out  1  clear the IF/ID register; fetch takes the redirect target.
REQ-015 valid_o  out  NSTAGE-2  per-stage valid bits; bit i-2 corresponds to stage i, for stages 2..NSTAGE-1.
REQ-016 fwd_a_sel_o, fwd_b_sel_o  out  SW each  EX operand source: 0 means register-file value; k means the result held in stage k.
REQ-017 id_byp_a_o, id_byp_b_o  out  1 each  the WB write-data matches the ID source; decode muxes WB data into that source.

Function
REQ-018 SHALL keep a per-stage record for stages 2..NSTAGE-1: valid, rd, reg_write, mem_read, rs1, rs2, use_rs1, use_rs2.
REQ-019 SHALL shift every record in stages 2..NSTAGE-2 into the next stage each cycle, unconditionally; the WB record retires.
REQ-020 A source "matches" stage k iff all hold: the stage is valid, it has reg_write, its rd is nonzero, the source is used, and rs equals rd.
REQ-021 SHALL set stall_o = id_valid_i AND (any ID source matches a hazard stage) AND NOT redirect, combinationally.
REQ-022 On stall_o: EX loads a bubble (valid=0); ID is held by the pipeline register.
REQ-023 Redirect = ex_redirect_i AND valid_o[2]. On redirect: flush_o=1, stall_o=0, and EX loads a bubble next cycle; the instruction in EX itself advances normally.
REQ-024 Otherwise EX loads the ID record with valid = id_valid_i.
REQ-025 Forward select: the lowest k in 3..NSTAGE-1 whose stage matches the EX source, excluding stage 3 when that stage is a load; 0 if none. Valid only when valid_o[0]=1; 0 otherwise.
REQ-026 id_byp_x_o SHALL be 1 iff ID source x matches stage NSTAGE-1.
REQ-027 Boundary rules: rd=0 never stalls, forwards or bypasses; multiple matches resolve to the youngest stage; redirect and stall in the same cycle resolve to redirect.

Reset
REQ-028 While reset_i=0 at a clock edge, all stage valids SHALL clear.
REQ-029 During reset, every output SHALL be 0.
REQ-030 Reset mid-operation SHALL discard all in-flight records; no stall or flush persists after reset releases.

Configuration
REQ-031 Macro HAZ_FWD_EN defined: forwarding per REQ-025; the hazard stage set is {stage 2 when it is a load}, giving a one-cycle load-use stall.
REQ-032 Macro HAZ_FWD_EN undefined: fwd_a_sel_o and fwd_b_sel_o are tied 0; the hazard stage set is stages 2..NSTAGE-2 for any writer; the bypass outputs are unchanged.

Verification (NSTAGE=5, AW=5)
REQ-033 FWD on: ALU writer x5 in EX, ID reads rs1=5 -> stall_o=0; next cycle fwd_a_sel_o=3.
REQ-034 FWD on: load x7 in EX, ID reads rs2=7 -> stall_o=1 for exactly 1 cycle. Next cycle valid_o[0]=0; when the consumer reaches EX, fwd_b_sel_o=4.
REQ-035 Writer with rd=0 followed by a reader of x0 -> stall_o, fwd_*, and id_byp_* all stay 0.
REQ-036 ex_redirect_i=1 with valid EX, plus a load-use match in the same cycle -> flush_o=1, stall_o=0; next cycle valid_o[0]=0.
REQ-037 FWD off: ALU writer x3, then a dependent reader -> stall_o=1 for 2 cycles, then id_byp_a_o=1 for 1 cycle; fwd_a_sel_o stays 0 throughout.
REQ-038 reset_i=0 for one edge with stages full -> valid_o=0 and all outputs 0 on the following cycle.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl
// Hazard detection, stall/flush generation and operand-forward selection
// for an in-order pipeline of NSTAGE stages (IF=0, ID=1, EX=2, MEM=3, WB=NSTAGE-1).
//
// Optional feature macro: HAZ_FWD_EN
//   defined   : EX forwarding enabled; only a load sitting in EX stalls ID (load-use).
//   undefined : no forwarding (fwd selects tied 0); any writer in EX..NSTAGE-2 stalls ID.
//
// Ports
//   clk_i            rising-edge clock
//   reset_i          synchronous active-low reset
//   id_valid_i       ID holds a real instruction
//   id_rs1_i/rs2_i   ID source registers, id_use_rs1_i/rs2_i qualify them
//   id_rd_i          ID destination, id_reg_write_i / id_mem_read_i its attributes
//   ex_redirect_i    EX resolved a taken branch/jump (honoured only if EX is valid)
//   stall_o          hold PC and IF/ID
//   flush_o          clear IF/ID, fetch redirect target
//   valid_o          valid bits of stages 2..NSTAGE-1 (bit i-2 = stage i)
//   fwd_a_sel_o/b    EX operand source: 0 = register file, k = stage k result
//   id_byp_a_o/b     WB write data bypassed into the ID source
module pipe_hazard_ctrl #(
  parameter  int NSTAGE = 5,
  parameter  int AW     = 5,
  localparam int SW     = $clog2(NSTAGE)
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              id_valid_i,
  input  logic [AW-1:0]     id_rs1_i,
  input  logic [AW-1:0]     id_rs2_i,
  input  logic              id_use_rs1_i,
  input  logic              id_use_rs2_i,
  input  logic [AW-1:0]     id_rd_i,
  input  logic              id_reg_write_i,
  input  logic              id_mem_read_i,
  input  logic              ex_redirect_i,
  output logic              stall_o,
  output logic              flush_o,
  output logic [NSTAGE-3:0] valid_o,
  output logic [SW-1:0]     fwd_a_sel_o,
  output logic [SW-1:0]     fwd_b_sel_o,
  output logic              id_byp_a_o,
  output logic              id_byp_b_o
);

  typedef struct packed {
    logic [AW-1:0] rd;
    logic          rw;
    logic          mr;
    logic [AW-1:0] rs1;
    logic [AW-1:0] rs2;
    logic          u1;
    logic          u2;
  } rec_t;

  // Stage records: valid bits are control (reset), payload is data (not reset).
  logic [NSTAGE-1:2] vld_q, vld_d;
  rec_t              rec_q [2:NSTAGE-1];
  rec_t              rec_d;

  logic              redirect;
  logic              haz;
  logic              stall_raw;
  logic [SW-1:0]     fwd_a, fwd_b;
  logic              unused_rec;

  function automatic logic src_match(input logic vld, input rec_t r,
                                     input logic used, input logic [AW-1:0] rs);
    return vld & r.rw & (r.rd != '0) & used & (rs == r.rd);
  endfunction

  assign redirect = ex_redirect_i & vld_q[2];

  // Hazard stage set depends on whether forwarding is available.
  always_comb begin
    haz = 1'b0;
`ifdef HAZ_FWD_EN
    if (rec_q[2].mr)
      haz = src_match(vld_q[2], rec_q[2], id_use_rs1_i, id_rs1_i) |
            src_match(vld_q[2], rec_q[2], id_use_rs2_i, id_rs2_i);
`else
    for (int k = 2; k <= NSTAGE-2; k++)
      haz |= src_match(vld_q[k], rec_q[k], id_use_rs1_i, id_rs1_i) |
             src_match(vld_q[k], rec_q[k], id_use_rs2_i, id_rs2_i);
`endif
  end

  // Redirect wins over stall: the stalled ID instruction is being flushed anyway.
  assign stall_raw = id_valid_i & haz & ~redirect;

  // Forward selection: scan oldest to youngest so the youngest match wins.
  // A load still in MEM has no data yet, so stage 3 is skipped for loads.
  always_comb begin
    fwd_a = '0;
    fwd_b = '0;
`ifdef HAZ_FWD_EN
    if (vld_q[2]) begin
      for (int k = NSTAGE-1; k >= 3; k--) begin
        if (!(k == 3 && rec_q[k].mr)) begin
          if (src_match(vld_q[k], rec_q[k], rec_q[2].u1, rec_q[2].rs1)) fwd_a = SW'(k);
          if (src_match(vld_q[k], rec_q[k], rec_q[2].u2, rec_q[2].rs2)) fwd_b = SW'(k);
        end
      end
    end
`endif
  end

  // Not every record field is consumed in every configuration.
  always_comb begin
    unused_rec = 1'b0;
    for (int k = 2; k <= NSTAGE-1; k++) unused_rec ^= ^rec_q[k];
  end

  // ID -> EX boundary: bubble on stall or redirect, else the ID instruction.
  always_comb begin
    rec_d = '{rd: id_rd_i, rw: id_reg_write_i, mr: id_mem_read_i,
              rs1: id_rs1_i, rs2: id_rs2_i, u1: id_use_rs1_i, u2: id_use_rs2_i};
    vld_d = vld_q;
    vld_d[2] = id_valid_i & ~stall_raw & ~redirect;
    for (int k = 3; k <= NSTAGE-1; k++) vld_d[k] = vld_q[k-1];
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i) vld_q <= '0;
    else          vld_q <= vld_d;
  end

  // EX -> ... -> WB boundaries: unconditional shift, WB retires.
  always_ff @(posedge clk_i) begin
    rec_q[2] <= rec_d;
    for (int k = 3; k <= NSTAGE-1; k++) rec_q[k] <= rec_q[k-1];
  end

  // All outputs forced low while reset is asserted.
  assign stall_o     = reset_i & stall_raw;
  assign flush_o     = reset_i & redirect;
  assign valid_o     = reset_i ? vld_q : '0;
  assign fwd_a_sel_o = reset_i ? fwd_a : '0;
  assign fwd_b_sel_o = reset_i ? fwd_b : '0;
  assign id_byp_a_o  = reset_i &
                       src_match(vld_q[NSTAGE-1], rec_q[NSTAGE-1], id_use_rs1_i, id_rs1_i);
  assign id_byp_b_o  = reset_i &
                       src_match(vld_q[NSTAGE-1], rec_q[NSTAGE-1], id_use_rs2_i, id_rs2_i);

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Testbench for pipe_hazard_ctrl (NSTAGE=5, AW=5). Directed steps; each step
// pushes its expected output vector and pops it at the sampling edge.
// Expected vector = {stall, flush, valid[2:0], fwd_a[2:0], fwd_b[2:0], byp_a, byp_b}.
module tb_pipe_hazard_ctrl;
  localparam int NSTAGE = 5;
  localparam int AW     = 5;
  localparam int SW     = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset_i;
  logic              id_valid_i;
  logic [AW-1:0]     id_rs1_i, id_rs2_i, id_rd_i;
  logic              id_use_rs1_i, id_use_rs2_i, id_reg_write_i, id_mem_read_i;
  logic              ex_redirect_i;
  logic              stall_o, flush_o, id_byp_a_o, id_byp_b_o;
  logic [NSTAGE-3:0] valid_o;
  logic [SW-1:0]     fwd_a_sel_o, fwd_b_sel_o;

  pipe_hazard_ctrl #(.NSTAGE(NSTAGE), .AW(AW)) dut (
    .clk_i(clk), .reset_i(reset_i), .id_valid_i(id_valid_i),
    .id_rs1_i(id_rs1_i), .id_rs2_i(id_rs2_i),
    .id_use_rs1_i(id_use_rs1_i), .id_use_rs2_i(id_use_rs2_i),
    .id_rd_i(id_rd_i), .id_reg_write_i(id_reg_write_i), .id_mem_read_i(id_mem_read_i),
    .ex_redirect_i(ex_redirect_i), .stall_o(stall_o), .flush_o(flush_o),
    .valid_o(valid_o), .fwd_a_sel_o(fwd_a_sel_o), .fwd_b_sel_o(fwd_b_sel_o),
    .id_byp_a_o(id_byp_a_o), .id_byp_b_o(id_byp_b_o)
  );

  typedef struct {
    string       tag;
    logic [12:0] exp;
  } sb_t;
  sb_t sb_q[$];

  int n_chk  = 0;
  int n_pass = 0;

  logic [12:0] obs;
  assign obs = {stall_o, flush_o, valid_o, fwd_a_sel_o, fwd_b_sel_o, id_byp_a_o, id_byp_b_o};

  function automatic logic [12:0] E(input logic st, input logic fl, input logic [2:0] v,
                                    input logic [2:0] fa, input logic [2:0] fb,
                                    input logic ba, input logic bb);
    return {st, fl, v, fa, fb, ba, bb};
  endfunction

  task automatic drv(input logic v, input logic [AW-1:0] rs1, input logic u1,
                     input logic [AW-1:0] rs2, input logic u2,
                     input logic [AW-1:0] rd, input logic rw, input logic mr);
    id_valid_i = v;   id_rs1_i = rs1; id_use_rs1_i = u1;
    id_rs2_i = rs2;   id_use_rs2_i = u2;
    id_rd_i = rd;     id_reg_write_i = rw; id_mem_read_i = mr;
  endtask

  task automatic idle();
    drv(1'b0, '0, 1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
  endtask

  // Inputs are already driven; push expectation, sample at negedge, advance.
  task automatic step(input string tag, input logic [12:0] exp);
    sb_t e;
    sb_q.push_back('{tag: tag, exp: exp});
    @(negedge clk);
    e = sb_q.pop_front();
    n_chk++;
    assert (obs === e.exp) n_pass++;
    else $error("FAIL %s: observed %h expected %h", e.tag, obs, e.exp);
    @(posedge clk);
    #1;
  endtask

  task automatic rst_pulse(input string tag);
    reset_i = 1'b0;
    ex_redirect_i = 1'b0;
    idle();
    step(tag, '0);
    reset_i = 1'b1;
  endtask

  initial begin
    reset_i = 1'b0;
    ex_redirect_i = 1'b0;
    idle();
    @(posedge clk);
    #1;
    // Reset with a live ID instruction: everything low.
    drv(1'b1, 5'd3, 1'b1, 5'd4, 1'b1, 5'd5, 1'b1, 1'b0);
    step("reset_outputs", '0);
    reset_i = 1'b1;
    idle();
    step("after_reset", '0);

    // rd = x0 writer followed by readers of x0: nothing ever fires.
    drv(1'b1, '0, 1'b0, '0, 1'b0, 5'd0, 1'b1, 1'b0);
    step("x0_w", E(0,0,3'b000,0,0,0,0));
    drv(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 1'b0);
    step("x0_r_ex", E(0,0,3'b001,0,0,0,0));
    step("x0_r_mem", E(0,0,3'b011,0,0,0,0));
    step("x0_r_wb", E(0,0,3'b111,0,0,0,0));

    // Redirect with a simultaneous load-use hazard: redirect wins.
    rst_pulse("rst_a");
    drv(1'b1, '0, 1'b0, '0, 1'b0, 5'd7, 1'b1, 1'b1);
    step("redir_load", E(0,0,3'b000,0,0,0,0));
    drv(1'b1, '0, 1'b0, 5'd7, 1'b1, 5'd8, 1'b1, 1'b0);
    ex_redirect_i = 1'b1;
    step("redir_flush", E(0,1,3'b001,0,0,0,0));
    ex_redirect_i = 1'b0;
    idle();
    step("redir_bubble", E(0,0,3'b010,0,0,0,0));
    ex_redirect_i = 1'b1;
    step("redir_ex_invalid", E(0,0,3'b100,0,0,0,0));
    ex_redirect_i = 1'b0;

`ifdef HAZ_FWD_EN
    // ALU writer x5 then reader rs1=5: no stall, forwarded from MEM.
    rst_pulse("rst_b");
    drv(1'b1, '0, 1'b0, '0, 1'b0, 5'd5, 1'b1, 1'b0);
    step("alu_w", E(0,0,3'b000,0,0,0,0));
    drv(1'b1, 5'd5, 1'b1, '0, 1'b0, 5'd6, 1'b1, 1'b0);
    step("alu_r_nostall", E(0,0,3'b001,0,0,0,0));
    idle();
    step("alu_fwd_mem", E(0,0,3'b011,3,0,0,0));

    // Load x7 then reader rs2=7: one-cycle stall, then forwarded from WB.
    rst_pulse("rst_c");
    drv(1'b1, '0, 1'b0, '0, 1'b0, 5'd7, 1'b1, 1'b1);
    step("ld_w", E(0,0,3'b000,0,0,0,0));
    drv(1'b1, '0, 1'b0, 5'd7, 1'b1, 5'd8, 1'b1, 1'b0);
    step("ld_use_stall", E(1,0,3'b001,0,0,0,0));
    step("ld_use_release", E(0,0,3'b010,0,0,0,0));
    idle();
    step("ld_fwd_wb", E(0,0,3'b101,0,4,0,0));

    // Two writers of x5: youngest (MEM) wins over WB.
    rst_pulse("rst_d");
    drv(1'b1, '0, 1'b0, '0, 1'b0, 5'd5, 1'b1, 1'b0);
    step("yng_w1", E(0,0,3'b000,0,0,0,0));
    step("yng_w2", E(0,0,3'b001,0,0,0,0));
    drv(1'b1, 5'd5, 1'b1, 5'd5, 1'b1, 5'd9, 1'b1, 1'b0);
    step("yng_r", E(0,0,3'b011,0,0,0,0));
    idle();
    step("yng_fwd", E(0,0,3'b111,3,3,0,0));
`else
    // ALU writer x3 then dependent reader: 2 stall cycles, then WB bypass.
    rst_pulse("rst_b");
    drv(1'b1, '0, 1'b0, '0, 1'b0, 5'd3, 1'b1, 1'b0);
    step("nf_w", E(0,0,3'b000,0,0,0,0));
    drv(1'b1, 5'd3, 1'b1, '0, 1'b0, 5'd10, 1'b1, 1'b0);
    step("nf_stall_ex", E(1,0,3'b001,0,0,0,0));
    step("nf_stall_mem", E(1,0,3'b010,0,0,0,0));
    step("nf_byp_wb", E(0,0,3'b100,0,0,1,0));
    idle();
    step("nf_reader_ex", E(0,0,3'b001,0,0,0,0));

    // rs2 bypass path.
    rst_pulse("rst_c");
    drv(1'b1, '0, 1'b0, '0, 1'b0, 5'd12, 1'b1, 1'b0);
    step("nf2_w", E(0,0,3'b000,0,0,0,0));
    idle();
    step("nf2_gap1", E(0,0,3'b001,0,0,0,0));
    step("nf2_gap2", E(0,0,3'b010,0,0,0,0));
    drv(1'b1, '0, 1'b0, 5'd12, 1'b1, 5'd1, 1'b1, 1'b0);
    step("nf2_byp_b", E(0,0,3'b100,0,0,0,1));
`endif

    // Fill all stages, then reset for one edge mid-operation.
    rst_pulse("rst_e");
    drv(1'b1, '0, 1'b0, '0, 1'b0, 5'd1, 1'b0, 1'b0);
    step("fill0", E(0,0,3'b000,0,0,0,0));
    step("fill1", E(0,0,3'b001,0,0,0,0));
    step("fill2", E(0,0,3'b011,0,0,0,0));
    step("full", E(0,0,3'b111,0,0,0,0));
    reset_i = 1'b0;
    step("midrst_during", '0);
    reset_i = 1'b1;
    idle();
    step("midrst_after", '0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
